// File: rtl/sx_wrr_sched_if.sv
// Scheduler request/grant bundle: per-port requests and weights in,
// registered grant, grant index, grant-valid and turn credit out.
interface sx_wrr_sched_if #(
    parameter int S_DATA_COUNT = 4,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int ID_WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

    logic [S_DATA_COUNT-1:0]                   req_i;
    logic [S_DATA_COUNT-1:0][WEIGHT_WIDTH-1:0] weight_i;
    logic                                      pkt_done_i;
    logic [S_DATA_COUNT-1:0]                   gnt_o;
    logic [ID_WIDTH-1:0]                       gnt_id_o;
    logic                                      gnt_valid_o;
    logic [WEIGHT_WIDTH-1:0]                   credit_o;

    // Requester / mux side
    modport master (
        output req_i, weight_i, pkt_done_i,
        input  gnt_o, gnt_id_o, gnt_valid_o, credit_o
    );

    // Scheduler side
    modport slave (
        input  req_i, weight_i, pkt_done_i,
        output gnt_o, gnt_id_o, gnt_valid_o, credit_o
    );
endinterface

// File: rtl/sx_wrr_sched.sv
// Weighted round-robin, packet-atomic scheduler for a shared AXI-Stream
// output. A granted port keeps the output until its packet's last beat is
// accepted, and may send up to weight_i[p] packets per turn.
module sx_wrr_sched #(
    parameter int S_DATA_COUNT = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    sx_wrr_sched_if.slave bus
);
    localparam int ID_WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;
    localparam int SW       = ID_WIDTH + 1;

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t                    r_state, w_state_nxt;
    logic [S_DATA_COUNT-1:0]   r_gnt, w_gnt_nxt;
    logic [ID_WIDTH-1:0]       r_gnt_id, w_gnt_id_nxt;
    logic                      r_gnt_valid, w_gnt_valid_nxt;
    logic [WEIGHT_WIDTH-1:0]   r_credit, w_credit_nxt;
    logic [ID_WIDTH-1:0]       r_ptr, w_ptr_nxt;

    logic [S_DATA_COUNT-1:0]   w_elig;
    logic                      w_cur_elig;
    logic [2*S_DATA_COUNT-1:0] w_rot;
    logic                      w_found;
    logic [SW-1:0]             w_found_sum;
    logic [ID_WIDTH-1:0]       w_found_id;
    logic [ID_WIDTH-1:0]       w_found_nptr;
    logic [S_DATA_COUNT-1:0]   w_found_oh;
    logic [WEIGHT_WIDTH-1:0]   w_found_wt;

    // Per-port eligibility; the current port is checked through the one-hot
    // grant, which is zero until the first grant and then matches gnt_id.
    always_comb begin
        w_elig = '0;
        for (int unsigned p = 0; p < S_DATA_COUNT; p++) begin
            w_elig[p] = bus.req_i[p] && (bus.weight_i[p] != '0);
        end
        w_cur_elig = |(w_elig & r_gnt);
    end

    // Rotating scan from ptr: the doubled eligibility vector shifted by ptr
    // puts port (ptr+k) mod N at bit k, so the first set bit is the winner.
    always_comb begin
        w_rot        = {w_elig, w_elig} >> r_ptr;
        w_found      = 1'b0;
        w_found_sum  = '0;
        w_found_id   = '0;
        w_found_nptr = '0;
        w_found_oh   = '0;
        w_found_wt   = '0;
        for (int unsigned k = 0; k < S_DATA_COUNT; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found     = 1'b1;
                w_found_sum = SW'(r_ptr) + SW'(k);
            end
        end
        if (w_found_sum >= SW'(S_DATA_COUNT)) begin
            w_found_sum = w_found_sum - SW'(S_DATA_COUNT);
        end
        w_found_id = w_found_sum[ID_WIDTH-1:0];
        if (SW'(w_found_id) + SW'(1) >= SW'(S_DATA_COUNT)) begin
            w_found_nptr = '0;
        end else begin
            w_found_nptr = w_found_id + ID_WIDTH'(1);
        end
        for (int unsigned p = 0; p < S_DATA_COUNT; p++) begin
            w_found_oh[p] = w_found && (w_found_id == ID_WIDTH'(p));
            if (w_found_oh[p]) begin
                w_found_wt = bus.weight_i[p];
            end
        end
    end

    // Next-state and output logic of the IDLE/GRANT controller
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_credit_nxt    = r_credit;
        w_ptr_nxt       = r_ptr;
        case (r_state)
            ST_IDLE: begin
                w_gnt_valid_nxt = 1'b0;
                if ((r_credit != '0) && w_cur_elig) begin
                    w_gnt_valid_nxt = 1'b1;
                    w_state_nxt     = ST_GRANT;
                end else if (w_found) begin
                    w_gnt_nxt       = w_found_oh;
                    w_gnt_id_nxt    = w_found_id;
                    w_credit_nxt    = w_found_wt;
                    w_ptr_nxt       = w_found_nptr;
                    w_gnt_valid_nxt = 1'b1;
                    w_state_nxt     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (bus.pkt_done_i) begin
                    w_gnt_valid_nxt = 1'b0;
                    w_credit_nxt    = (r_credit == '0) ? '0 : r_credit - WEIGHT_WIDTH'(1);
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_credit    <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_credit    <= w_credit_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    assign bus.gnt_o       = r_gnt;
    assign bus.gnt_id_o    = r_gnt_id;
    assign bus.gnt_valid_o = r_gnt_valid;
    assign bus.credit_o    = r_credit;
endmodule

// File: tb/tb_sx_wrr_sched.sv
// Bench for sx_wrr_sched: a turn-level scheduler model checked every cycle,
// plus directed scenarios with hand-computed grant sequences.
module tb_sx_wrr_sched;
    localparam int N  = 4;
    localparam int WW = 4;

    logic clk;
    logic reset_n;

    sx_wrr_sched_if #(.S_DATA_COUNT(N), .WEIGHT_WIDTH(WW)) bus ();

    sx_wrr_sched #(.S_DATA_COUNT(N), .WEIGHT_WIDTH(WW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who holds the output, how many packets are left in the turn,
    // where the next rotation search starts, and whether anyone was granted yet.
    typedef struct {
        bit valid;
        bit ever;
        int id;
        int credit;
        int ptr;
    } mst_t;

    mst_t m;
    bit   m_init = 1'b0;

    function automatic mst_t step(input mst_t s, input bit rst_n, input logic [N-1:0] req,
                                  input logic [N-1:0][WW-1:0] w, input bit done);
        mst_t r;
        int   p;
        r = s;
        if (!rst_n) begin
            r = '{valid: 1'b0, ever: 1'b0, id: 0, credit: 0, ptr: 0};
            return r;
        end
        if (s.valid) begin
            if (done) begin
                r.valid = 1'b0;
                if (r.credit > 0) r.credit = r.credit - 1;
            end
            return r;
        end
        if (s.credit > 0 && req[s.id[1:0]] && w[s.id[1:0]] != 0) begin
            r.valid = 1'b1;
            return r;
        end
        for (int k = 0; k < N; k++) begin
            p = (s.ptr + k) % N;
            if (req[p[1:0]] && w[p[1:0]] != 0) begin
                r.id     = p;
                r.credit = int'(w[p[1:0]]);
                r.ptr    = (p + 1) % N;
                r.valid  = 1'b1;
                r.ever   = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m <= step(m, reset_n, bus.req_i, bus.weight_i, bus.pkt_done_i);
        if (!reset_n) m_init <= 1'b1;
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        logic [N-1:0] exp_gnt;
        if (m_init) begin
            exp_gnt = m.ever ? (N'(1) << m.id) : '0;
            n_cmp++;
            if (bus.gnt_valid_o !== m.valid) begin
                n_bad++;
                $display("FAIL model_valid t=%0t got %b expected %b", $time, bus.gnt_valid_o, m.valid);
            end
            n_cmp++;
            if (bus.gnt_o !== exp_gnt) begin
                n_bad++;
                $display("FAIL model_gnt t=%0t got %b expected %b", $time, bus.gnt_o, exp_gnt);
            end
            n_cmp++;
            if (bus.gnt_id_o !== m.id[1:0]) begin
                n_bad++;
                $display("FAIL model_gnt_id t=%0t got %0d expected %0d", $time, bus.gnt_id_o, m.id);
            end
            n_cmp++;
            if (bus.credit_o !== m.credit[WW-1:0]) begin
                n_bad++;
                $display("FAIL model_credit t=%0t got %0d expected %0d", $time, bus.credit_o, m.credit);
            end
            n_cmp++;
            if ($countones(bus.gnt_o) > 1) begin
                n_bad++;
                $display("FAIL onehot t=%0t got %b expected at most one bit", $time, bus.gnt_o);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Called at a negedge; returns the number of cycles waited for a grant.
    task automatic wait_valid(output int t);
        t = 0;
        while (!bus.gnt_valid_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.gnt_valid_o) chk("grant_timeout", 0, 1);
    endtask

    // Waits for a grant, records it, and pulses pkt_done for one cycle.
    task automatic do_pkt(output int id, output int cr, output int t);
        wait_valid(t);
        id = int'(bus.gnt_id_o);
        cr = int'(bus.credit_o);
        bus.pkt_done_i = 1'b1;
        @(negedge clk);
        bus.pkt_done_i = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int id, cr, t;
    int exp2_id[6]   = '{0, 1, 2, 3, 0, 1};
    int exp3_id[12]  = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 3, 3};
    int exp3_cr[12]  = '{3, 2, 1, 1, 2, 1, 3, 2, 1, 1, 2, 1};

    initial begin
        reset_n        = 1'b0;
        bus.req_i      = '0;
        bus.weight_i   = '0;
        bus.pkt_done_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // No requests: nothing granted for 10 cycles
        bus.weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid", int'(bus.gnt_valid_o), 0);
        end
        chk("idle_gnt", int'(bus.gnt_o), 0);
        chk("idle_credit", int'(bus.credit_o), 0);

        // Equal weights: plain rotation with a single idle cycle between packets
        apply_reset();
        bus.req_i = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            do_pkt(id, cr, t);
            chk("rr_id", id, exp2_id[i]);
            chk("rr_credit", cr, 1);
            chk("rr_latency", t, 1);
            chk("rr_gap_low", int'(bus.gnt_valid_o), 0);
        end

        // Weights p0=3 p1=1 p2=0 p3=2
        apply_reset();
        bus.weight_i = {4'd2, 4'd0, 4'd1, 4'd3};
        bus.req_i    = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            do_pkt(id, cr, t);
            chk("wrr_id", id, exp3_id[i]);
            chk("wrr_credit", cr, exp3_cr[i]);
            chk("wrr_latency", t, 1);
        end

        // Early turn end: p0 drops its request, remaining credit discarded
        apply_reset();
        bus.weight_i = {4'd0, 4'd0, 4'd2, 4'd4};
        bus.req_i    = 4'b0001;
        do_pkt(id, cr, t);
        chk("early_first_id", id, 0);
        chk("early_first_credit", cr, 4);
        bus.req_i = 4'b0010;
        do_pkt(id, cr, t);
        chk("early_next_id", id, 1);
        chk("early_next_credit", cr, 2);
        chk("early_latency", t, 1);

        // Packet-atomic hold: request dropped mid-packet does not revoke grant
        apply_reset();
        bus.weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
        bus.req_i    = 4'b0100;
        wait_valid(t);
        chk("hold_id", int'(bus.gnt_id_o), 2);
        bus.req_i = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(bus.gnt_valid_o), 1);
            chk("hold_id_kept", int'(bus.gnt_id_o), 2);
        end
        bus.pkt_done_i = 1'b1;
        @(negedge clk);
        bus.pkt_done_i = 1'b0;
        chk("hold_release", int'(bus.gnt_valid_o), 0);

        // Reset mid-grant with credit 2, then restart scanning from port 0
        apply_reset();
        bus.weight_i = {4'd1, 4'd0, 4'd3, 4'd0};
        bus.req_i    = 4'b1010;
        do_pkt(id, cr, t);
        chk("rst_pre_id", id, 1);
        chk("rst_pre_credit", cr, 3);
        wait_valid(t);
        chk("rst_regrant_credit", int'(bus.credit_o), 2);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_valid", int'(bus.gnt_valid_o), 0);
        chk("rst_gnt", int'(bus.gnt_o), 0);
        chk("rst_credit", int'(bus.credit_o), 0);
        do_pkt(id, cr, t);
        chk("rst_post_id", id, 1);
        chk("rst_post_credit", cr, 3);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sx_wrr_sched.md
Name: sx_wrr_sched

Overview:
- Weighted round-robin, packet-atomic scheduler for a shared AXI-Stream output.
- Decides which of S_DATA_COUNT input streams owns the output and holds that grant until the granted packet's last beat is accepted.
- Each port may send up to weight_i[p] consecutive packets per turn before the grant rotates.
- Drives the select inputs of a grant-indexed stream mux and watches that mux's output handshake.

Parameters:
S_DATA_COUNT, 4, number of requesting streams (>=1)
WEIGHT_WIDTH, 4, width of per-port weight and credit counter
ID_WIDTH, max(1,$clog2(S_DATA_COUNT)), localparam, grant index width

Ports:
clk  input  1  clock
reset_n  input  1  reset, synchronous, active-low
req_i  input  S_DATA_COUNT  per-port request (stream tvalid)
weight_i  input  S_DATA_COUNT x WEIGHT_WIDTH  packets per turn; 0 = port disabled
pkt_done_i  input  1  last beat of granted packet accepted (m_valid & m_ready & m_last)
gnt_o  output  S_DATA_COUNT  one-hot grant, registered
gnt_id_o  output  ID_WIDTH  binary index of gnt_o, registered
gnt_valid_o  output  1  grant active; mux may pass data only when high
credit_o  output  WEIGHT_WIDTH  packets remaining in current turn, including the one in flight

Behaviour:
- One clock: clk. Reset: reset_n, synchronous, active-low, sampled only on rising clk.
- Reset values:
  - gnt_o=0, gnt_id_o=0, gnt_valid_o=0, credit_o=0.
  - Internal RR pointer ptr=0, i.e. search starts at port 0.
  - State=IDLE.
- A port is eligible when req_i[p]=1 and weight_i[p]!=0.
- State IDLE:
  - If credit_o>0 and the current port (gnt_id_o) is eligible: re-grant the same port. Credit is unchanged, the turn continues.
  - Otherwise: pick the first eligible port scanning ptr, ptr+1, ... with wrap at S_DATA_COUNT-1 -> 0.
    - Register gnt_o/gnt_id_o to that port.
    - Load credit_o = weight_i[port]. Weight is sampled only at turn start; later weight changes affect the next turn only.
    - Set ptr = port+1, wrapping.
  - If any grant is issued: gnt_valid_o=1 next cycle, state -> GRANT.
  - No eligible port: stay IDLE, outputs hold their values, gnt_valid_o=0.
- State GRANT:
  - gnt_o, gnt_id_o, gnt_valid_o are held regardless of req_i. Grant is packet-atomic; a dropped request does not revoke it.
  - On pkt_done_i=1: credit_o decrements by 1, saturating at 0. Next cycle gnt_valid_o=0 and state -> IDLE.
  - gnt_o/gnt_id_o keep their last value while IDLE; gnt_valid_o qualifies them.
- Latency:
  - Request to gnt_valid_o is 1 cycle.
  - pkt_done_i to gnt_valid_o low is 1 cycle.
  - Exactly one IDLE cycle between consecutive packets, even on re-grant.
  - Single-beat packets therefore get at most 50% output utilisation. This is accepted.
- pkt_done_i is ignored in IDLE.
- Turn end:
  - Credit reaching 0 forces rotation at the next IDLE.
  - If the current port is not eligible in IDLE, the turn ends early: remaining credit is discarded and rotation happens.
- If the current port is the only eligible port after its credit is exhausted, the scan from ptr wraps back to it. It is re-granted with credit reloaded.
- Weight change to 0 during GRANT: the current packet completes, then the port is skipped.
- Reset asserted mid-packet: grant drops on that clock edge. The downstream mux must discard the partial packet; that is outside this block.
- S_DATA_COUNT=1: gnt_o=1 whenever gnt_valid_o; gnt_id_o=0.
- Invariants:
  - gnt_o is one-hot or zero.
  - gnt_o == (1<<gnt_id_o) once the first grant has been issued.
  - credit_o <= 2^WEIGHT_WIDTH-1.

Test Plan:
- Reset, then req_i=4'b0000 for 10 cycles -> gnt_valid_o=0, gnt_o=0, credit_o=0 throughout.
- weights all 1, req_i=4'b1111 held, pkt_done_i pulsed 1 cycle after each gnt_valid_o rise -> gnt_id_o sequence 0,1,2,3,0,1; one gnt_valid_o-low cycle between each.
- weights {p0=3,p1=1,p2=0,p3=2}, req_i=4'b1111 held, 12 packets -> gnt_id_o sequence 0,0,0,1,3,3,0,0,0,1,3,3; port 2 never granted; credit_o=3,2,1 for p0's packets.
- p0 weight 4, granted; after 1st packet drop req_i[0], req_i[1]=1 -> next grant to port 1 with credit_o=weight_i[1]; p0's remaining credit discarded.
- granted port 2, req_i[2] drops to 0 for 5 cycles with no pkt_done_i -> gnt_valid_o stays 1, gnt_id_o stays 2; later pkt_done_i -> gnt_valid_o=0 next cycle.
- reset_n=0 for one cycle mid-GRANT, with credit_o=2 -> next cycle gnt_valid_o=0, gnt_o=0, credit_o=0; first post-reset grant is to the lowest eligible port scanning from 0.
